// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction-fetch stage plus the IF/ID pipeline register.
//   - Owns the fetch PC and drives the instruction-memory address from it.
//   - Latches the fetched word and its PC.
//   - Presents the 11-bit opcode to the control unit.
//   - Resolves B / BLT / CBZ redirects coming back from the resolve stage.
//     A taken redirect flushes the wrong-path IF/ID entry.
//
// Optional build macro:
//   FETCH_PERF_CNT_EN - adds the 32-bit fetch_count and flush_count output
//                       ports and their counters.
//
// Update priority on each clock edge:
//   reset > redirect > stall > normal fetch.
// A redirect wins over a stall so that a taken branch is never lost while
// the hazard unit is holding the front end.
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  stall,
  input  logic                  br_valid,
  input  logic                  uncond_br,
  input  logic                  cond_br,
  input  logic                  br_is_cbz,
  input  logic                  flag_zero,
  input  logic                  flag_neg,
  input  logic                  flag_ovf,
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic [25:0]           br_imm,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic                  if_id_valid,
  output logic [10:0]           opcode,
  output logic                  br_taken
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           flush_count
`endif
);

  // Sequential PC increment (one 32-bit instruction).
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(3'd4);

  // Sign-extend the 26-bit B offset to ADDR_WIDTH and scale it to bytes.
  function automatic logic [ADDR_WIDTH-1:0] sext26_x4(input logic [25:0] imm);
    logic [ADDR_WIDTH-1:0] ext;
    ext = {{(ADDR_WIDTH-26){imm[25]}}, imm};
    return {ext[ADDR_WIDTH-3:0], 2'b00};
  endfunction

  // Sign-extend the 19-bit conditional offset to ADDR_WIDTH and scale it.
  function automatic logic [ADDR_WIDTH-1:0] sext19_x4(input logic [18:0] imm);
    logic [ADDR_WIDTH-1:0] ext;
    ext = {{(ADDR_WIDTH-19){imm[18]}}, imm};
    return {ext[ADDR_WIDTH-3:0], 2'b00};
  endfunction

  // Architectural state.
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] if_id_pc_r;
  logic [31:0]           if_id_instr_r;
  logic                  if_id_valid_r;

  // Next-state and decode signals.
  logic [ADDR_WIDTH-1:0] pc_nxt_s;
  logic [ADDR_WIDTH-1:0] if_id_pc_nxt_s;
  logic [31:0]           if_id_instr_nxt_s;
  logic                  if_id_valid_nxt_s;
  logic                  cond_met_s;
  logic                  taken_s;
  logic [ADDR_WIDTH-1:0] imm_off_s;
  logic [ADDR_WIDTH-1:0] target_s;
  logic                  fetch_en_s;

  // Evaluate the branch condition.
  // br_valid gates every other branch input, so garbage on an invalid
  // resolve slot can never redirect the front end.
  always_comb begin
    cond_met_s = 1'b0;
    taken_s    = 1'b0;
    if (br_is_cbz) begin
      cond_met_s = flag_zero;
    end else begin
      cond_met_s = flag_neg ^ flag_ovf;
    end
    if (br_valid) begin
      taken_s = uncond_br | (cond_br & cond_met_s);
    end else begin
      taken_s = 1'b0;
    end
  end

  // Compute the branch target.
  // B uses imm26. BLT and CBZ use imm19; the upper bits of br_imm are ignored
  // for those. The addition wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    imm_off_s = {ADDR_WIDTH{1'b0}};
    if (uncond_br) begin
      imm_off_s = sext26_x4(br_imm);
    end else begin
      imm_off_s = sext19_x4(br_imm[18:0]);
    end
    target_s = br_pc + imm_off_s;
  end

  // Select the next PC and IF/ID contents: redirect, then stall, then fetch.
  // A flush clears the instruction word so that an invalid entry always
  // carries 32'h0. The PC of the flushed entry is left unchanged.
  always_comb begin
    pc_nxt_s          = pc_r;
    if_id_pc_nxt_s    = if_id_pc_r;
    if_id_instr_nxt_s = if_id_instr_r;
    if_id_valid_nxt_s = if_id_valid_r;
    fetch_en_s        = 1'b0;
    if (taken_s) begin
      pc_nxt_s          = target_s;
      if_id_instr_nxt_s = 32'h0000_0000;
      if_id_valid_nxt_s = 1'b0;
    end else if (stall) begin
      pc_nxt_s          = pc_r;
      if_id_pc_nxt_s    = if_id_pc_r;
      if_id_instr_nxt_s = if_id_instr_r;
      if_id_valid_nxt_s = if_id_valid_r;
    end else begin
      fetch_en_s        = 1'b1;
      pc_nxt_s          = pc_r + PC_STEP;
      if_id_pc_nxt_s    = pc_r;
      if_id_instr_nxt_s = imem_rdata;
      if_id_valid_nxt_s = 1'b1;
    end
  end

  // Register the PC and IF/ID state; synchronous reset has top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      if_id_pc_r    <= {ADDR_WIDTH{1'b0}};
      if_id_instr_r <= 32'h0000_0000;
      if_id_valid_r <= 1'b0;
    end else begin
      pc_r          <= pc_nxt_s;
      if_id_pc_r    <= if_id_pc_nxt_s;
      if_id_instr_r <= if_id_instr_nxt_s;
      if_id_valid_r <= if_id_valid_nxt_s;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_r;
  logic [31:0] flush_count_r;

  // Count normal fetches and redirect flushes; stall edges count neither.
  // Both counters wrap at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_r <= 32'h0000_0000;
      flush_count_r <= 32'h0000_0000;
    end else begin
      if (fetch_en_s) begin
        fetch_count_r <= fetch_count_r + 32'h0000_0001;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
      if (taken_s) begin
        flush_count_r <= flush_count_r + 32'h0000_0001;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign fetch_count = fetch_count_r;
  assign flush_count = flush_count_r;
`endif

  // Output mapping.
  // The memory address follows the registered PC. br_taken is deliberately
  // combinational so that the hazard unit can squash the resolve-side slot
  // in the same cycle.
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign if_id_pc    = if_id_pc_r;
  assign if_id_instr = if_id_instr_r;
  assign if_id_valid = if_id_valid_r;
  assign opcode      = if_id_instr_r[31:21];
  assign br_taken    = taken_s;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch.
//   - Directed vector table.
//   - Hand-written wrap and counter sequences.
//   - Randomized run checked against an arithmetic reference model.
//   Define FETCH_PERF_CNT_EN to build and check the performance counters.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, br_valid, uncond_br, cond_br, br_is_cbz;
  logic        flag_zero, flag_neg, flag_ovf;
  logic [63:0] br_pc;
  logic [25:0] br_imm;
  logic [63:0] imem_addr, pc, if_id_pc;
  logic [31:0] imem_rdata, if_id_instr;
  logic        if_id_valid, br_taken;
  logic [10:0] opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, flush_count;
`endif

  instr_fetch #(.ADDR_WIDTH(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .br_valid(br_valid), .uncond_br(uncond_br), .cond_br(cond_br),
    .br_is_cbz(br_is_cbz), .flag_zero(flag_zero), .flag_neg(flag_neg),
    .flag_ovf(flag_ovf), .br_pc(br_pc), .br_imm(br_imm), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .opcode(opcode), .br_taken(br_taken)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  // Instruction memory: a distinct, address-derived word with varied opcode bits.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state, kept as plain variables.
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr, m_fc, m_flc;
  bit          m_valid;

  // Branch resolution from the rules, as plain boolean tests.
  function automatic bit ref_taken();
    if (!br_valid)  return 1'b0;
    if (uncond_br)  return 1'b1;
    if (!cond_br)   return 1'b0;
    if (br_is_cbz)  return flag_zero;
    return flag_neg != flag_ovf;
  endfunction

  // Branch target as signed integer arithmetic.
  function automatic logic [63:0] ref_target();
    longint off;
    if (uncond_br) off = longint'($signed(br_imm));
    else           off = longint'($signed(br_imm[18:0]));
    return br_pc + 64'(off * 4);
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_fc = 32'h0; m_flc = 32'h0;
  endtask

  // One clock edge.
  // Before the edge: check the combinational outputs.
  // Then advance the model, and after the edge check every registered output.
  task automatic step();
    bit          t;
    logic [63:0] tg;
    #1;
    t  = ref_taken();
    tg = ref_target();
    check("br_taken", {63'h0, br_taken}, {63'h0, t});
    check("imem_addr", imem_addr, m_pc);
    if (reset) begin
      model_reset();
    end else if (t) begin
      m_pc = tg; m_valid = 1'b0; m_instr = 32'h0; m_flc = m_flc + 32'h1;
    end else if (!stall) begin
      m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 64'h4; m_fc = m_fc + 32'h1;
    end
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("if_id_pc", if_id_pc, m_ipc);
    check("if_id_instr", {32'h0, if_id_instr}, {32'h0, m_instr});
    check("if_id_valid", {63'h0, if_id_valid}, {63'h0, m_valid});
    check("opcode", {53'h0, opcode}, {53'h0, m_instr[31:21]});
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", {32'h0, fetch_count}, {32'h0, m_fc});
    check("flush_count", {32'h0, flush_count}, {32'h0, m_flc});
`endif
  endtask

  task automatic drive(input bit rst, stl, bv, ub, cb, cbz, z, n, v,
                       input logic [63:0] bpc, input logic [25:0] imm);
    reset = rst; stall = stl; br_valid = bv; uncond_br = ub; cond_br = cb;
    br_is_cbz = cbz; flag_zero = z; flag_neg = n; flag_ovf = v;
    br_pc = bpc; br_imm = imm;
  endtask

  typedef struct {
    bit          rst, stl, bv, ub, cb, cbz, z, n, v;
    logic [63:0] bpc;
    logic [25:0] imm;
    logic [63:0] e_pc, e_ipc;
    bit          e_valid, e_taken;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Table columns:
    //   rst stl bv ub cb cbz z n v | br_pc imm | exp pc, exp if_id_pc, exp valid, exp taken
    tbl[0]  = '{1,0,0,0,0,0,0,0,0, 64'h0,    26'h0,       64'h0,    64'h0,    0, 0};
    tbl[1]  = '{0,0,0,0,0,0,0,0,0, 64'h0,    26'h0,       64'h4,    64'h0,    1, 0};
    tbl[2]  = '{0,0,0,0,0,0,0,0,0, 64'h0,    26'h0,       64'h8,    64'h4,    1, 0};
    tbl[3]  = '{0,1,0,0,0,0,0,0,0, 64'h0,    26'h0,       64'h8,    64'h4,    1, 0};
    tbl[4]  = '{0,1,0,0,0,0,0,0,0, 64'h0,    26'h0,       64'h8,    64'h4,    1, 0};
    tbl[5]  = '{0,0,0,0,0,0,0,0,0, 64'h0,    26'h0,       64'hC,    64'h8,    1, 0};
    tbl[6]  = '{0,0,1,1,0,0,0,0,0, 64'h40,   26'h3FFFFFE, 64'h38,   64'h8,    0, 1};
    tbl[7]  = '{0,0,0,0,0,0,0,0,0, 64'h0,    26'h0,       64'h3C,   64'h38,   1, 0};
    tbl[8]  = '{0,0,1,0,1,1,1,0,0, 64'h100,  26'h5,       64'h114,  64'h38,   0, 1};
    tbl[9]  = '{0,0,1,0,1,1,0,0,0, 64'h100,  26'h5,       64'h118,  64'h114,  1, 0};
    tbl[10] = '{0,0,1,0,1,0,0,1,0, 64'h200,  26'h7FFFF,   64'h1FC,  64'h114,  0, 1};
    tbl[11] = '{0,0,1,0,1,0,0,1,1, 64'h200,  26'h7FFFF,   64'h200,  64'h1FC,  1, 0};
    tbl[12] = '{0,1,1,1,0,0,0,0,0, 64'h1000, 26'h10,      64'h1040, 64'h1FC,  0, 1};
    tbl[13] = '{0,0,0,1,1,1,1,0,0, 64'h1000, 26'h10,      64'h1044, 64'h1040, 1, 0};
    tbl[14] = '{0,0,1,0,1,1,1,0,0, 64'h80,   26'h3F80003, 64'h8C,   64'h1040, 0, 1};

    // Bring the DUT to a known state before any checking starts.
    drive(1,0,0,0,0,0,0,0,0, 64'h0, 26'h0);
    @(posedge clk);
    #1;
    model_reset();

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].bv, tbl[i].ub, tbl[i].cb, tbl[i].cbz,
            tbl[i].z, tbl[i].n, tbl[i].v, tbl[i].bpc, tbl[i].imm);
      #1;
      check($sformatf("vec%0d_taken", i), {63'h0, br_taken}, {63'h0, tbl[i].e_taken});
      step();
      check($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
      check($sformatf("vec%0d_ipc", i), if_id_pc, tbl[i].e_ipc);
      check($sformatf("vec%0d_valid", i), {63'h0, if_id_valid}, {63'h0, tbl[i].e_valid});
      check($sformatf("vec%0d_instr", i), {32'h0, if_id_instr},
            {32'h0, tbl[i].e_valid ? mem_word(tbl[i].e_ipc) : 32'h0});
    end

    // PC wrap: branch to 2^64-4, then one normal fetch wraps the PC to 0.
    drive(0,0,1,1,0,0,0,0,0, 64'h0, 26'h3FFFFFF);
    step();
    check("wrap_pre_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0,0,0,0,0,0,0,0,0, 64'h0, 26'h0);
    step();
    check("wrap_pc", pc, 64'h0);
    check("wrap_ipc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

`ifdef FETCH_PERF_CNT_EN
    // Counter sequence: 5 fetches, 2 stalls, then 1 redirect.
    drive(1,0,0,0,0,0,0,0,0, 64'h0, 26'h0);
    step();
    drive(0,0,0,0,0,0,0,0,0, 64'h0, 26'h0);
    for (int i = 0; i < 5; i++) step();
    drive(0,1,0,0,0,0,0,0,0, 64'h0, 26'h0);
    step();
    step();
    drive(0,0,1,1,0,0,0,0,0, 64'h300, 26'h4);
    step();
    check("cnt_fetch", {32'h0, fetch_count}, 64'd5);
    check("cnt_flush", {32'h0, flush_count}, 64'd1);
`endif

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 3, $urandom_range(0, 2) == 0,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            {$urandom, $urandom}, 26'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
